// File: rtl/immgen_pipe.sv
// immgen_pipe: pipelined RISC-V immediate generator with format classifier, illegal counter and skid buffer
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   flush                 synchronous drop of all held entries
//   in_valid/in_ready     input handshake for instr
//   instr                 32-bit instruction word
//   out_valid/out_ready   output handshake for imm/fmt/illegal
//   imm, fmt, illegal     decoded immediate, format code (0=R..6=SHAMT,7=ILLEGAL), fmt==7
//   illegal_cnt           saturating count of illegal words delivered
module immgen_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [2:0]       fmt,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);
  localparam logic [2:0] F_R = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3,
                         F_U = 3'd4, F_J = 3'd5, F_SH = 3'd6, F_ILL = 3'd7;
  localparam bit RV64 = (XLEN == 64);
  logic signed [31:0] s;
  logic [5:0]         sh;
  logic [2:0]         d_fmt;
  logic [XLEN-1:0]    d_imm;
  logic               skid_valid;
  logic [XLEN-1:0]    skid_imm;
  logic [2:0]         skid_fmt;
  // Immediates are built as signed 32-bit values and then widened; only SHAMT is zero-extended.
  always_comb begin
    s = '0;
    sh = '0;
    d_fmt = F_ILL;
    case (instr[6:0])
      7'b0110111, 7'b0010111: begin d_fmt = F_U; s = {instr[31:12], 12'b0}; end
      7'b1101111: begin d_fmt = F_J; s = 32'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0})); end
      7'b1100111, 7'b0000011: begin d_fmt = F_I; s = 32'($signed(instr[31:20])); end
      7'b0100011: begin d_fmt = F_S; s = 32'($signed({instr[31:25], instr[11:7]})); end
      7'b1100011: begin d_fmt = F_B; s = 32'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})); end
      7'b0110011: d_fmt = F_R;
      7'b0010011: begin
        d_fmt = (instr[13:12] == 2'b01) ? F_SH : F_I;
        sh = RV64 ? instr[25:20] : {1'b0, instr[24:20]};
        s = 32'($signed(instr[31:20]));
      end
      7'b0011011: if (RV64) begin
        d_fmt = (instr[13:12] == 2'b01) ? F_SH : F_I;
        sh = {1'b0, instr[24:20]};
        s = 32'($signed(instr[31:20]));
      end
      7'b0111011: if (RV64) d_fmt = F_R;
      default: ;
    endcase
    d_imm = (d_fmt == F_SH) ? XLEN'(sh) : XLEN'($signed(s));
  end
  assign in_ready = ~skid_valid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      imm         <= '0;
      fmt         <= '0;
      illegal     <= 1'b0;
      skid_valid  <= 1'b0;
      skid_imm    <= '0;
      skid_fmt    <= '0;
      illegal_cnt <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready && illegal && !(&illegal_cnt))
        illegal_cnt <= illegal_cnt + 1'b1;
      if (!out_valid || out_ready) begin
        // Output slot frees up: the skid entry is older than anything on the input, so it goes first.
        if (skid_valid) begin
          imm        <= skid_imm;
          fmt        <= skid_fmt;
          illegal    <= (skid_fmt == F_ILL);
          out_valid  <= 1'b1;
          skid_valid <= 1'b0;
        end else begin
          out_valid <= in_valid;
          if (in_valid) begin
            imm     <= d_imm;
            fmt     <= d_fmt;
            illegal <= (d_fmt == F_ILL);
          end
        end
      end else if (in_valid && !skid_valid) begin
        skid_imm   <= d_imm;
        skid_fmt   <= d_fmt;
        skid_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_immgen_pipe.sv
// tb_immgen_pipe: directed self-checking bench for immgen_pipe (RV32, RV64 and 2-bit counter instances)
module tb_immgen_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errs = 0;
  int   checks = 0;
  always #5 clk = ~clk;

  logic        a_fl = 0, a_v = 0, a_or = 1, a_ir, a_ov, a_ill;
  logic [31:0] a_i = 0, a_imm;
  logic [2:0]  a_fmt;
  logic [7:0]  a_cnt;
  immgen_pipe #(.XLEN(32), .CNT_W(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(a_fl), .in_valid(a_v), .in_ready(a_ir), .instr(a_i),
    .out_valid(a_ov), .out_ready(a_or), .imm(a_imm), .fmt(a_fmt), .illegal(a_ill), .illegal_cnt(a_cnt));

  logic        b_v = 0, b_ir, b_ov, b_ill;
  logic [31:0] b_i = 0;
  logic [63:0] b_imm;
  logic [2:0]  b_fmt;
  logic [7:0]  b_cnt;
  immgen_pipe #(.XLEN(64), .CNT_W(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(b_v), .in_ready(b_ir), .instr(b_i),
    .out_valid(b_ov), .out_ready(1'b1), .imm(b_imm), .fmt(b_fmt), .illegal(b_ill), .illegal_cnt(b_cnt));

  logic        c_v = 0, c_ir, c_ov, c_ill;
  logic [31:0] c_i = 0, c_imm;
  logic [2:0]  c_fmt;
  logic [1:0]  c_cnt;
  immgen_pipe #(.XLEN(32), .CNT_W(2)) dutc2 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(c_v), .in_ready(c_ir), .instr(c_i),
    .out_valid(c_ov), .out_ready(1'b1), .imm(c_imm), .fmt(c_fmt), .illegal(c_ill), .illegal_cnt(c_cnt));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [31:0] w1[5] = '{32'h000042B7, 32'h0080056F, 32'h013A0663, 32'h00912223, 32'h40C55593};
  logic [31:0] e1[5] = '{32'h4000, 32'd8, 32'd12, 32'd4, 32'd12};
  logic [2:0]  f1[5] = '{3'd4, 3'd5, 3'd3, 3'd2, 3'd6};
  logic [31:0] w2[4] = '{32'hFFB88D13, 32'h800002B7, 32'h02849293, 32'h0000001B};
  logic [63:0] e2[4] = '{64'hFFFFFFFFFFFFFFFB, 64'hFFFFFFFF80000000, 64'd40, 64'd0};
  logic [2:0]  f2[4] = '{3'd1, 3'd4, 3'd6, 3'd1};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    chk("rst_ov", a_ov, 0); chk("rst_ir", a_ir, 1); chk("rst_imm", a_imm, 0);
    chk("rst_fmt", a_fmt, 0); chk("rst_ill", a_ill, 0); chk("rst_cnt", a_cnt, 0);
    @(negedge clk) rst_n = 1;
    // streaming at full rate, then addi -5 on RV32
    @(negedge clk) begin a_v = 1; a_i = w1[0]; end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t1_ov", a_ov, 1); chk("t1_imm", a_imm, e1[k]); chk("t1_fmt", a_fmt, f1[k]);
      a_i = (k < 4) ? w1[(k + 1) % 5] : 32'hFFB88D13;
    end
    @(negedge clk);
    chk("t2_imm32", a_imm, 32'hFFFFFFFB); chk("t2_fmt32", a_fmt, 1);
    a_v = 0;
    @(negedge clk) chk("t1_idle", a_ov, 0);
    // RV64 extension and 6-bit shamt
    b_v = 1; b_i = w2[0];
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t2_ov64", b_ov, 1); chk("t2_imm64", b_imm, e2[k]); chk("t2_fmt64", b_fmt, f2[k]);
      if (k < 3) b_i = w2[k + 1]; else b_v = 0;
    end
    // backpressure through the skid register
    a_or = 0; a_v = 1; a_i = 32'h00100093;
    @(negedge clk) begin chk("t3_ir0", a_ir, 1); a_i = 32'h00200093; end
    @(negedge clk) begin chk("t3_ir1", a_ir, 0); chk("t3_immA", a_imm, 1); a_i = 32'h00300093; end
    @(negedge clk) begin chk("t3_ir2", a_ir, 0); chk("t3_holdA", a_imm, 1); chk("t3_ovA", a_ov, 1); a_or = 1; end
    @(negedge clk) begin chk("t3_immB", a_imm, 2); chk("t3_ir3", a_ir, 1); end
    @(negedge clk) begin chk("t3_immC", a_imm, 3); chk("t3_ovC", a_ov, 1); a_v = 0; end
    @(negedge clk) chk("t3_drain", a_ov, 0);
    // illegal detection and counting
    a_v = 1; a_i = 32'h0000007F;
    @(negedge clk) begin chk("t4_ill", a_ill, 1); chk("t4_fmt", a_fmt, 7); chk("t4_imm", a_imm, 0); chk("t4_cnt0", a_cnt, 0); a_i = 32'h0000001B; end
    @(negedge clk) begin chk("t4_ill32", a_ill, 1); chk("t4_fmt32", a_fmt, 7); chk("t4_cnt1", a_cnt, 1); a_v = 0; end
    @(negedge clk) begin chk("t4_cnt2", a_cnt, 2); chk("t4_idle", a_ov, 0); end
    c_v = 1; c_i = 32'h0000007F;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("t4_sat_step", c_cnt, (k - 1 > 3) ? 3 : k - 1);
    end
    c_v = 0;
    @(negedge clk) chk("t4_sat", c_cnt, 3);
    @(negedge clk) chk("t4_sat_hold", c_cnt, 3);
    // flush with output stalled and skid full, then a word offered during flush
    a_or = 0; a_v = 1; a_i = 32'h0000007F;
    @(negedge clk) begin chk("t5_ir0", a_ir, 1); a_i = 32'h00100093; end
    @(negedge clk) begin chk("t5_full", a_ir, 0); chk("t5_fmt", a_fmt, 7); a_fl = 1; a_i = 32'h00500093; end
    @(negedge clk) begin chk("t5_ov", a_ov, 0); chk("t5_ir", a_ir, 1); chk("t5_cnt", a_cnt, 2); a_i = 32'h00700093; end
    @(negedge clk) begin chk("t5_drop", a_ov, 0); a_fl = 0; a_v = 0; a_or = 1; end
    @(negedge clk) begin chk("t5_empty", a_ov, 0); chk("t5_cnt_keep", a_cnt, 2); end
    // asynchronous reset while stalled
    a_or = 0; a_v = 1; a_i = 32'h00100093;
    @(negedge clk) a_i = 32'h00200093;
    @(negedge clk) begin a_v = 0; chk("t6_full", a_ir, 0); end
    #2 rst_n = 0;
    #1;
    chk("t6_ov", a_ov, 0); chk("t6_ir", a_ir, 1); chk("t6_imm", a_imm, 0);
    chk("t6_fmt", a_fmt, 0); chk("t6_ill", a_ill, 0); chk("t6_cnt", a_cnt, 0);
    @(negedge clk) begin rst_n = 1; a_or = 1; a_v = 1; a_i = 32'hFFB88D13; chk("t6_pre", a_ov, 0); end
    @(negedge clk) begin chk("t6_ov1", a_ov, 1); chk("t6_imm1", a_imm, 32'hFFFFFFFB); a_v = 0; end
    @(negedge clk) chk("t6_idle", a_ov, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
